hypot_rr_sched: RTL

//  Shares one iterative hypotenuse engine, floor(sqrt(x^2+y^2)), between NREQ requesters.

---
 rtl/hypot_pkg.sv | 22 ++
 rtl/isqrt_iter.sv | 66 ++++++
 rtl/hypot_rr_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/hypot_pkg.sv
// rtl/hypot_pkg.sv - shared state encoding and width helpers for the hypotenuse scheduler
package hypot_pkg;

  typedef enum logic [1:0] {IDLE, SUMSQ, ROOT, DONE} state_t;

  function automatic int sum_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int root_w(input int w);
    return w + 1;
  endfunction

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int nit);
    return (nit > 1) ? $clog2(nit) : 1;
  endfunction

endpackage

// File: rtl/isqrt_iter.sv
// rtl/isqrt_iter.sv - restoring bit-serial integer square root, one root bit per step
module isqrt_iter
  import hypot_pkg::*;
#(
  parameter int SW = 17,
  parameter int RW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic [SW-1:0] radicand,
  output logic          done,
  output logic [RW-1:0] root
);

  localparam int CW = cnt_w(RW);
  localparam int PW = 2 * RW;

  logic [PW-1:0] rad_q;
  logic [RW:0]   rem_q;
  logic [RW-1:0] root_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [RW+2:0] rem_sh;
  logic [RW+2:0] trial;
  logic [RW:0]   diff;
  logic          ge;

  // Remainder never exceeds 2*root, so RW+1 bits hold it and the low bits of the difference suffice.
  always_comb begin
    rem_sh = {rem_q, rad_q[PW-1 -: 2]};
    trial  = {1'b0, root_q, 2'b01};
    ge     = (rem_sh >= trial);
    diff   = rem_sh[RW:0] - trial[RW:0];
    root   = {root_q[RW-2:0], ge};
    done   = run_q && step && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      rad_q  <= {{(PW-SW){1'b0}}, radicand};
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CW'(RW - 1);
      run_q  <= 1'b1;
    end else if (step && run_q) begin
      rad_q  <= {rad_q[PW-3:0], 2'b00};
      rem_q  <= ge ? diff : rem_sh[RW:0];
      root_q <= root;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hypot_rr_sched.sv
// rtl/hypot_rr_sched.sv - round-robin shared floor(sqrt(x^2+y^2)) engine with tagged response
module hypot_rr_sched
  import hypot_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int NREQ = 2,
  localparam int IW   = id_w(NREQ),
  localparam int SW   = sum_w(W),
  localparam int RW   = root_w(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IW-1:0]     resp_id,
  output logic [RW-1:0]     resp_root,
  output logic              busy
);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id_q;
  logic [IW-1:0] grant;
  logic          found;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic [SW-1:0] sum_q;
  logic [SW-1:0] xs;
  logic [SW-1:0] ys;
  logic          start_q;
  logic          sq_step;
  logic          sq_done;
  logic [RW-1:0] sq_root;

  // Search starts one past the last winner and wraps, so idle slots are skipped.
  always_comb begin
    int j;
    found = 1'b0;
    grant = '0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        grant = IW'(j);
      end
    end
  end

  assign req_ready = (state == IDLE && found) ? (NREQ'(1) << grant) : '0;
  assign busy      = (state != IDLE);
  assign xs        = SW'(x_q);
  assign ys        = SW'(y_q);
  assign sq_step   = (state == ROOT) && !start_q;

  isqrt_iter #(
    .SW(SW),
    .RW(RW)
  ) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start   (start_q),
    .step    (sq_step),
    .radicand(sum_q),
    .done    (sq_done),
    .root    (sq_root)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IW'(NREQ - 1);
      id_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sum_q      <= '0;
      start_q    <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_root  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            x_q   <= req_x[grant*W +: W];
            y_q   <= req_y[grant*W +: W];
            id_q  <= grant;
            ptr   <= grant;
            state <= SUMSQ;
          end
        end
        SUMSQ: begin
          sum_q   <= xs * xs + ys * ys;
          start_q <= 1'b1;
          state   <= ROOT;
        end
        ROOT: begin
          start_q <= 1'b0;
          if (sq_done) begin
            resp_valid <= 1'b1;
            resp_root  <= sq_root;
            resp_id    <= id_q;
            state      <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE first leaves a one-cycle bubble before the next accept.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
